// File: rtl/icw_init_sequencer.sv
// Bus master that writes the 8259A initialization words ICW1..ICW4 through a CS/WR/A0/data interface.
// Optional macro ICW_SEQ_OCW1_EN appends an OCW1 (interrupt mask) write after the last ICW.
module icw_init_sequencer #(
    parameter int SETUP_CYCLES    = 1,
    parameter int WR_PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] icw1_vector_address,
    input  logic       icw1_level_or_edge,
    input  logic       icw1_interval_4_or_8,
    input  logic       icw1_single_or_cascade,
    input  logic       icw1_set_icw4,
    input  logic [7:0] icw2_byte,
    input  logic [7:0] icw3_byte,
    input  logic [7:0] icw4_byte,
`ifdef ICW_SEQ_OCW1_EN
    input  logic [7:0] ocw1_mask,
`endif
    output logic       chip_select_n,
    output logic       write_enable_n,
    output logic       address_a0,
    output logic [7:0] data_bus_out,
    output logic       data_bus_enable,
    output logic       busy,
    output logic       done
);

    localparam int MAX_A = (SETUP_CYCLES > WR_PULSE_CYCLES) ? SETUP_CYCLES : WR_PULSE_CYCLES;
    localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(WR_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    localparam logic [1:0] W_ICW1 = 2'd0;
    localparam logic [1:0] W_ICW2 = 2'd1;
    localparam logic [1:0] W_ICW3 = 2'd2;
    localparam logic [1:0] W_ICW4 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      idx_q;
    logic [7:0]      icw1_q;
    logic [7:0]      icw2_q;
    logic [7:0]      icw3_q;
    logic [7:0]      icw4_q;
    logic            cs_n_q;
    logic            we_n_q;
    logic            a0_q;
    logic [7:0]      data_q;
    logic            den_q;
    logic            busy_q;
    logic            done_q;

    logic            more_d;
    logic [1:0]      idx_d;
    logic            nxt_a0_d;
    logic [7:0]      nxt_data_d;
`ifdef ICW_SEQ_OCW1_EN
    logic            ocw_q;
    logic [7:0]      ocw1_q;
    logic            ocw_d;
`endif

    // A0 and data for a given ICW index; ICW1 is the only word written with A0=0.
    function automatic logic [8:0] encode_word(input logic [1:0] idx,
                                               input logic [7:0] w1, input logic [7:0] w2,
                                               input logic [7:0] w3, input logic [7:0] w4);
        case (idx)
            W_ICW1:  return {1'b0, w1};
            W_ICW2:  return {1'b1, w2};
            W_ICW3:  return {1'b1, w3};
            W_ICW4:  return {1'b1, w4};
            default: return {1'b0, w1};
        endcase
    endfunction

    // Which word follows the current one: ICW3 only in cascade mode, ICW4 only when IC4 is set.
    always_comb begin
        more_d = 1'b0;
        idx_d  = idx_q;
        case (idx_q)
            W_ICW1: begin
                more_d = 1'b1;
                idx_d  = W_ICW2;
            end
            W_ICW2: begin
                if (!icw1_q[1]) begin
                    more_d = 1'b1;
                    idx_d  = W_ICW3;
                end else if (icw1_q[0]) begin
                    more_d = 1'b1;
                    idx_d  = W_ICW4;
                end else begin
                    more_d = 1'b0;
                    idx_d  = idx_q;
                end
            end
            W_ICW3: begin
                if (icw1_q[0]) begin
                    more_d = 1'b1;
                    idx_d  = W_ICW4;
                end else begin
                    more_d = 1'b0;
                    idx_d  = idx_q;
                end
            end
            W_ICW4: begin
                more_d = 1'b0;
                idx_d  = idx_q;
            end
            default: begin
                more_d = 1'b0;
                idx_d  = idx_q;
            end
        endcase
        {nxt_a0_d, nxt_data_d} = encode_word(idx_d, icw1_q, icw2_q, icw3_q, icw4_q);
`ifdef ICW_SEQ_OCW1_EN
        ocw_d = 1'b0;
        if (ocw_q) begin
            more_d = 1'b0;
        end else if (!more_d) begin
            more_d     = 1'b1;
            ocw_d      = 1'b1;
            nxt_a0_d   = 1'b1;
            nxt_data_d = ocw1_q;
        end else begin
            ocw_d = 1'b0;
        end
`endif
    end

    // Sequencer FSM with registered bus outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= W_ICW1;
            icw1_q  <= 8'h00;
            icw2_q  <= 8'h00;
            icw3_q  <= 8'h00;
            icw4_q  <= 8'h00;
            cs_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            a0_q    <= 1'b0;
            data_q  <= 8'h00;
            den_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ICW_SEQ_OCW1_EN
            ocw_q   <= 1'b0;
            ocw1_q  <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        icw1_q  <= {icw1_vector_address, 1'b1, icw1_level_or_edge,
                                    icw1_interval_4_or_8, icw1_single_or_cascade, icw1_set_icw4};
                        icw2_q  <= icw2_byte;
                        icw3_q  <= icw3_byte;
                        icw4_q  <= icw4_byte;
                        data_q  <= {icw1_vector_address, 1'b1, icw1_level_or_edge,
                                    icw1_interval_4_or_8, icw1_single_or_cascade, icw1_set_icw4};
                        a0_q    <= 1'b0;
                        idx_q   <= W_ICW1;
                        cnt_q   <= CNT_ZERO;
                        cs_n_q  <= 1'b0;
                        we_n_q  <= 1'b1;
                        den_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
`ifdef ICW_SEQ_OCW1_EN
                        ocw_q   <= 1'b0;
                        ocw1_q  <= ocw1_mask;
`endif
                    end
                end
                S_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= CNT_ZERO;
                        we_n_q  <= 1'b0;
                        state_q <= S_STROBE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                S_STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        cnt_q   <= CNT_ZERO;
                        we_n_q  <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q <= CNT_ZERO;
                        if (more_d) begin
                            // chip select stays low across the word boundary
                            idx_q   <= idx_d;
                            a0_q    <= nxt_a0_d;
                            data_q  <= nxt_data_d;
                            state_q <= S_SETUP;
`ifdef ICW_SEQ_OCW1_EN
                            ocw_q   <= ocw_d;
`endif
                        end else begin
                            cs_n_q  <= 1'b1;
                            den_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            a0_q    <= 1'b0;
                            data_q  <= 8'h00;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    cs_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    den_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign chip_select_n   = cs_n_q;
    assign write_enable_n  = we_n_q;
    assign address_a0      = a0_q;
    assign data_bus_out    = data_q;
    assign data_bus_enable = den_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_icw_init_sequencer.sv
// Directed bench for icw_init_sequencer: expected bus writes are queued at launch and
// popped as each write strobe falls; done timing and count are checked per sequence.
module tb_icw_init_sequencer;

    localparam int WR_PULSE = 2;
    localparam int WORD_LEN = 4;
`ifdef ICW_SEQ_OCW1_EN
    localparam int OCW_WORDS = 1;
`else
    localparam int OCW_WORDS = 0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] icw1_vector_address = 3'd0;
    logic       icw1_level_or_edge = 1'b0;
    logic       icw1_interval_4_or_8 = 1'b0;
    logic       icw1_single_or_cascade = 1'b0;
    logic       icw1_set_icw4 = 1'b0;
    logic [7:0] icw2_byte = 8'h00;
    logic [7:0] icw3_byte = 8'h00;
    logic [7:0] icw4_byte = 8'h00;
    logic [7:0] ocw1_mask = 8'hFB;
    logic       chip_select_n;
    logic       write_enable_n;
    logic       address_a0;
    logic [7:0] data_bus_out;
    logic       data_bus_enable;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int exp_done = -1;
    int done_cnt = 0;
    int done_base = 0;
    logic [8:0] exp_q[$];

    icw_init_sequencer dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .start                  (start),
        .icw1_vector_address    (icw1_vector_address),
        .icw1_level_or_edge     (icw1_level_or_edge),
        .icw1_interval_4_or_8   (icw1_interval_4_or_8),
        .icw1_single_or_cascade (icw1_single_or_cascade),
        .icw1_set_icw4          (icw1_set_icw4),
        .icw2_byte              (icw2_byte),
        .icw3_byte              (icw3_byte),
        .icw4_byte              (icw4_byte),
`ifdef ICW_SEQ_OCW1_EN
        .ocw1_mask              (ocw1_mask),
`endif
        .chip_select_n          (chip_select_n),
        .write_enable_n         (write_enable_n),
        .address_a0             (address_a0),
        .data_bus_out           (data_bus_out),
        .data_bus_enable        (data_bus_enable),
        .busy                   (busy),
        .done                   (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: pops the scoreboard on each falling strobe, checks pulse width and done timing.
    initial begin : monitor
        logic       prev_we;
        int         low_cnt;
        logic [8:0] e;
        prev_we = 1'b1;
        low_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_we = 1'b1;
                low_cnt = 0;
            end else begin
                if (!write_enable_n && prev_we) begin
                    chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("write_word", {23'd0, address_a0, data_bus_out}, {23'd0, e});
                        chk("write_cs_den", {30'd0, chip_select_n, data_bus_enable}, 32'd1);
                    end
                end
                if (write_enable_n && !prev_we)
                    chk("strobe_width", low_cnt, WR_PULSE);
                low_cnt = write_enable_n ? 0 : low_cnt + 1;
                if (done) begin
                    done_cnt++;
                    chk("done_cycle", cyc, exp_done);
                end
                prev_we = write_enable_n;
            end
        end
    end

    task automatic set_cfg(input logic [2:0] vec, input logic ltim, input logic adi,
                           input logic sngl, input logic ic4,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        icw1_vector_address    = vec;
        icw1_level_or_edge     = ltim;
        icw1_interval_4_or_8   = adi;
        icw1_single_or_cascade = sngl;
        icw1_set_icw4          = ic4;
        icw2_byte              = b2;
        icw3_byte              = b3;
        icw4_byte              = b4;
    endtask

    task automatic push(input logic a0, input logic [7:0] d);
        exp_q.push_back({a0, d});
    endtask

    // Called at a negedge: pulses start for one cycle and records T0.
    task automatic launch(input int n_icw);
        if (OCW_WORDS != 0) push(1'b1, ocw1_mask);
        done_base = done_cnt;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t0 = cyc;
        exp_done = t0 + WORD_LEN * (n_icw + OCW_WORDS);
        chk("t0_busy_cs_den_we", {28'd0, busy, chip_select_n, data_bus_enable, write_enable_n}, 32'b1011);
    endtask

    task automatic finish(input bit poke_done);
        int g;
        g = 0;
        while (cyc < exp_done + 3 && g < 200) begin
            @(negedge clock);
            start = poke_done && done;
            g++;
        end
        start = 1'b0;
        chk("window_reached", cyc, exp_done + 3);
        chk("idle_busy_cs_den", {29'd0, busy, chip_select_n, data_bus_enable}, 32'b010);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_count", done_cnt - done_base, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_outputs", {20'd0, chip_select_n, write_enable_n, address_a0, data_bus_out,
                            data_bus_enable, busy, done}, {20'd0, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000});
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // single, no ICW4
        set_cfg(3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00);
        push(1'b0, 8'hBA); push(1'b1, 8'h40);
        launch(2);
        finish(1'b0);

        // cascade with ICW4
        set_cfg(3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 8'h04, 8'h01);
        push(1'b0, 8'h15); push(1'b1, 8'h08); push(1'b1, 8'h04); push(1'b1, 8'h01);
        launch(4);
        finish(1'b0);

        // single with ICW4; start poked during DONE must be ignored
        set_cfg(3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 8'h77, 8'h03);
        push(1'b0, 8'hBB); push(1'b1, 8'h40); push(1'b1, 8'h03);
        launch(3);
        finish(1'b1);

        // start and config change mid-sequence: no restart, latched ICW2 used
        set_cfg(3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00);
        push(1'b0, 8'hBA); push(1'b1, 8'h40);
        launch(2);
        repeat (3) @(negedge clock);
        start = 1'b1;
        icw2_byte = 8'hC0;
        @(negedge clock);
        start = 1'b0;
        finish(1'b0);

        // reset during ICW2 strobe
        icw2_byte = 8'h40;
        push(1'b0, 8'hBA); push(1'b1, 8'h40);
        launch(2);
        repeat (5) @(negedge clock);
        chk("icw2_strobe_low", {31'd0, write_enable_n}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst", {28'd0, write_enable_n, chip_select_n, data_bus_enable, busy}, 32'b1100);
        exp_q.delete();
        done_base = done_cnt;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        chk("no_done_after_rst", done_cnt - done_base, 0);
        chk("idle_after_rst", {31'd0, busy}, 32'd0);

        // full run after reset
        push(1'b0, 8'hBA); push(1'b1, 8'h40);
        launch(2);
        finish(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icw_init_sequencer.md
Name: icw_init_sequencer

Overview:
- Host-side bus master that drives the 8259A initialization sequence (ICW1, ICW2, optional ICW3, optional ICW4) onto the chip-select/write/A0/data interface.
- The PIC's ICW1/ICW2/ICW3/ICW4 capture registers are the receiving end of this interface.
- Used by the system-level bench and boot logic to program the controller from configuration fields, with no CPU model.

Parameters:
- SETUP_CYCLES, 1, cycles with cs_n low and data valid before the write strobe falls (>=1)
- WR_PULSE_CYCLES, 2, cycles write_enable_n is held low (>=1)
- HOLD_CYCLES, 1, cycles data and cs_n are held after the write strobe rises (>=1)

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run the sequence; sampled only in IDLE
- icw1_vector_address  in  3  ICW1 D7..D5
- icw1_level_or_edge  in  1  ICW1 D3 (LTIM)
- icw1_interval_4_or_8  in  1  ICW1 D2 (ADI)
- icw1_single_or_cascade  in  1  ICW1 D1 (SNGL); 0 means ICW3 is sent
- icw1_set_icw4  in  1  ICW1 D0 (IC4); 1 means ICW4 is sent
- icw2_byte  in  8  ICW2 value
- icw3_byte  in  8  ICW3 value
- icw4_byte  in  8  ICW4 value
- chip_select_n  out  1  active-low chip select
- write_enable_n  out  1  active-low write strobe
- address_a0  out  1  A0 line
- data_bus_out  out  8  write data
- data_bus_enable  out  1  1 while data_bus_out is driven
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (async, immediate): state=IDLE; chip_select_n=1, write_enable_n=1, address_a0=0, data_bus_out=0, data_bus_enable=0, busy=0, done=0; shadow registers cleared.
- All outputs are registered.
- States:
  - IDLE: waits for start.
  - SETUP: SETUP_CYCLES cycles.
  - STROBE: WR_PULSE_CYCLES cycles.
  - HOLD: HOLD_CYCLES cycles.
  - DONE: 1 cycle.
- A phase counter is sized for max(SETUP_CYCLES, WR_PULSE_CYCLES, HOLD_CYCLES). A 2-bit word index selects ICW1..ICW4.
- IDLE and start=1 at edge T0:
  - Latch all config inputs into shadow registers.
  - Word index = ICW1; enter SETUP.
  - From T0: busy=1, chip_select_n=0, data_bus_enable=1.
  - Later changes to config inputs have no effect until the next start.
- Word encoding:
  - ICW1: A0=0, data = {vector[2:0], 1'b1, LTIM, ADI, SNGL, IC4}. D4 is always forced to 1.
  - ICW2: A0=1, data = icw2_byte.
  - ICW3: A0=1, data = icw3_byte. Sent only when latched SNGL=0.
  - ICW4: A0=1, data = icw4_byte. Sent only when latched IC4=1.
- Per word:
  - SETUP: write_enable_n=1.
  - STROBE: write_enable_n=0.
  - HOLD: write_enable_n=1.
  - chip_select_n=0 and address/data stable throughout all three phases.
- After HOLD:
  - If a further word is required, advance the index (skipping disabled words) and re-enter SETUP. chip_select_n stays low across the word boundary.
  - Otherwise enter DONE.
- DONE: chip_select_n=1, data_bus_enable=0, busy=0, done=1 for one cycle; then IDLE.
- Word length = SETUP_CYCLES+WR_PULSE_CYCLES+HOLD_CYCLES (4 with defaults). done asserts N*4 cycles after T0 for N words.
- start outside IDLE (including during DONE) is ignored; there is no queuing.
- Reset asserted mid-sequence: write_enable_n and chip_select_n deassert immediately. No done is produced. After release the block sits in IDLE.

Optional Feature:
- Macro: ICW_SEQ_OCW1_EN.
- Defined:
  - Adds input ocw1_mask [7:0], latched at start with the other config.
  - After the last ICW, one extra word is written: A0=1, data = ocw1_mask. This programs the interrupt mask register.
  - done is delayed by one word.
- Undefined: the port and the extra word are absent; behaviour is exactly as above.

Test Plan:
- Single, no ICW4: vector=3'b101, LTIM=1, ADI=0, SNGL=1, IC4=0, icw2=8'h40 -> writes (A0=0, 8'hBA), (A0=1, 8'h40); write_enable_n low 2 cycles each; done at T0+8.
- Cascade with ICW4: vector=0, LTIM=0, ADI=1, SNGL=0, IC4=1, icw2=8'h08, icw3=8'h04, icw4=8'h01 -> writes 8'h15, 8'h08, 8'h04, 8'h01 with A0 sequence 0,1,1,1; done at T0+16.
- Single with ICW4: SNGL=1, IC4=1, icw4=8'h03 -> three writes; ICW3 skipped; third write is A0=1, 8'h03; done at T0+12.
- start pulsed mid-sequence while icw2_byte changes from 8'h40 to 8'hC0 -> no restart; ICW2 written as 8'h40; exactly one done.
- reset_n low during the ICW2 STROBE phase -> write_enable_n=1, chip_select_n=1, data_bus_enable=0, busy=0 asynchronously; no done after release; a new start runs the full sequence.
- ICW_SEQ_OCW1_EN defined, ocw1_mask=8'hFB, single/no ICW4 -> third write (A0=1, 8'hFB); done at T0+12.
